// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
// The pipeline side drives hazard and multi-cycle request information.
// The controller side returns the per-stage stall vector and status.
// Signals are level-based and are sampled on the rising clock edge.
// ex_mc_req stays high until ex_mc_done pulses.
// ex_mc_done is a one-cycle acknowledge, so no separate ready is needed.
interface pipe_stall_ctrl_if #(
   parameter int CNT_W = 6
);
   logic             id_rs_rd_en;
   logic [4:0]       id_rs_addr;
   logic             id_rt_rd_en;
   logic [4:0]       id_rt_addr;
   logic             ex_is_load;
   logic             ex_wrn;
   logic [4:0]       ex_wrAddr;
   logic             ex_mc_req;
   logic             ex_mc_cancel;
   logic [5:0]       stall;
   logic             mc_busy;
   logic [CNT_W-1:0] mc_count;
   logic             ex_mc_done;
   logic [1:0]       dbg_state;

   // Pipeline side
   modport master (
      output id_rs_rd_en, id_rs_addr, id_rt_rd_en, id_rt_addr,
      output ex_is_load, ex_wrn, ex_wrAddr, ex_mc_req, ex_mc_cancel,
      input  stall, mc_busy, mc_count, ex_mc_done, dbg_state
   );

   // Stall controller side
   modport slave (
      input  id_rs_rd_en, id_rs_addr, id_rt_rd_en, id_rt_addr,
      input  ex_is_load, ex_wrn, ex_wrAddr, ex_mc_req, ex_mc_cancel,
      output stall, mc_busy, mc_count, ex_mc_done, dbg_state
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller for the 6-stage pipeline.
// A load-use hazard stalls PC, IF_ID and ID_EX while EX keeps running.
// Because EX runs with ID_EX stalled, one bubble goes into EX.
// A multi-cycle EX op holds PC through EX for MC_CYCLES cycles.
// The op then gets a one-cycle done pulse and EX_MEM captures the result.
module pipe_stall_ctrl #(
   parameter int MC_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_stall_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 2);
   localparam logic [5:0] STALL_MC   = 6'b001111;
   localparam logic [5:0] STALL_LU   = 6'b000111;
   localparam logic [5:0] STALL_NONE = 6'b000000;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, done_q;
   logic             load_use;
   logic [5:0]       stall_d;

   // Load-use hazard: the EX load targets a register that ID is reading.
   always_comb begin
      load_use = bus.ex_is_load & bus.ex_wrn & (bus.ex_wrAddr != 5'd0) &
                 ((bus.id_rs_rd_en & (bus.id_rs_addr == bus.ex_wrAddr)) |
                  (bus.id_rt_rd_en & (bus.id_rt_addr == bus.ex_wrAddr)));
   end

   // Next state, the counter update and the combinational stall vector.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      stall_d = STALL_NONE;
      case (state_q)
         IDLE: begin
            if (bus.ex_mc_req && !bus.ex_mc_cancel) begin
               stall_d = STALL_MC;
               count_d = MC_LOAD;
               state_d = RUN;
            end else if (bus.ex_mc_req && bus.ex_mc_cancel) begin
               stall_d = STALL_NONE;
               count_d = '0;
            end else begin
               stall_d = load_use ? STALL_LU : STALL_NONE;
            end
         end
         RUN: begin
            if (bus.ex_mc_cancel) begin
               stall_d = STALL_NONE;
               count_d = '0;
               state_d = IDLE;
            end else begin
               stall_d = STALL_MC;
               if (count_q == '0) begin
                  state_d = DONE;
               end else begin
                  count_d = count_q - CNT_W'(1);
               end
            end
         end
         DONE: begin
            // The request still seen here belongs to the op that just finished.
            stall_d = load_use ? STALL_LU : STALL_NONE;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
      if (rst) begin
         stall_d = STALL_NONE;
      end
   end

   // State, counter and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.stall      = stall_d;
   assign bus.mc_busy    = busy_q;
   assign bus.mc_count   = count_q;
   assign bus.ex_mc_done = done_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl.
// It covers reset, load-use, multi-cycle timing, back-to-back ops, cancel and overlap.
module tb_pipe_stall_ctrl;

   localparam int MC    = 32;
   localparam int CNT_W = 6;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   // Packed expectation: {stall[5:0], mc_busy, mc_count[5:0], ex_mc_done}
   logic [13:0] exp_q[$];

   pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_stall_ctrl #(.MC_CYCLES(MC), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string tag, input string field,
                      input logic [5:0] obs, input logic [5:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s.%s: observed %b expected %b", tag, field, obs, exp_v);
      end
   endtask

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic check(input string tag);
      logic [13:0] e;
      if (exp_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s.queue: observed empty expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         cmp(tag, "stall", bus.stall, e[13:8]);
         cmp(tag, "busy",  {5'd0, bus.mc_busy}, {5'd0, e[7]});
         cmp(tag, "count", bus.mc_count, e[6:1]);
         cmp(tag, "done",  {5'd0, bus.ex_mc_done}, {5'd0, e[0]});
      end
   endtask

   // Drive one cycle of control inputs, record the expectation, then sample it.
   task automatic step(input string tag, input logic r, input logic req, input logic can,
                       input logic [5:0] e_stall, input logic e_busy,
                       input logic [5:0] e_cnt, input logic e_done);
      @(negedge clk);
      rst              = r;
      bus.ex_mc_req    = req;
      bus.ex_mc_cancel = can;
      exp_q.push_back({e_stall, e_busy, e_cnt, e_done});
      #1;
      check(tag);
   endtask

   task automatic set_lu(input logic is_load, input logic wrn, input logic [4:0] wr,
                         input logic rs_en, input logic [4:0] rs,
                         input logic rt_en, input logic [4:0] rt);
      bus.ex_is_load  = is_load;
      bus.ex_wrn      = wrn;
      bus.ex_wrAddr   = wr;
      bus.id_rs_rd_en = rs_en;
      bus.id_rs_addr  = rs;
      bus.id_rt_rd_en = rt_en;
      bus.id_rt_addr  = rt;
   endtask

   // One full multi-cycle op: request seen at T, done at T+MC.
   task automatic mc_run(input string tag, input logic req_done, input logic can_done,
                         input logic [5:0] done_stall);
      step(tag, 1'b0, 1'b1, 1'b0, 6'b001111, 1'b0, 6'd0, 1'b0);
      for (int i = 1; i < MC; i++) begin
         step(tag, 1'b0, 1'b1, 1'b0, 6'b001111, 1'b1, 6'(MC - 1 - i), 1'b0);
      end
      step({tag, "_done"}, 1'b0, req_done, can_done, done_stall, 1'b0, 6'd0, 1'b1);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.ex_mc_req    = 1'b0;
      bus.ex_mc_cancel = 1'b0;
      set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      repeat (2) @(posedge clk);

      // Reset state
      step("reset", 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      step("idle",  1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);

      // Load-use via rs, then each qualifier removed
      set_lu(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
      step("lu_rs", 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0, 6'd0, 1'b0);
      set_lu(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
      step("lu_r0", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      set_lu(1'b1, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0);
      step("lu_rs_off", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      set_lu(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7);
      step("lu_rt", 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0, 6'd0, 1'b0);
      set_lu(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7);
      step("lu_noload", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      set_lu(1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7);
      step("lu_nowrn", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      set_lu(1'b1, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 5'd8);
      step("lu_nomatch", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

      // Single multi-cycle op, request held through DONE, then released
      mc_run("mc", 1'b1, 1'b0, 6'b000000);
      step("mc_after", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);

      // Back-to-back: IDLE re-arms at T+33, second done at T+65
      mc_run("b2b1", 1'b1, 1'b0, 6'b000000);
      mc_run("b2b2", 1'b0, 1'b0, 6'b000000);
      step("b2b_after", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);

      // Cancel at T+10
      step("cancel", 1'b0, 1'b1, 1'b0, 6'b001111, 1'b0, 6'd0, 1'b0);
      for (int i = 1; i < 10; i++) begin
         step("cancel", 1'b0, 1'b1, 1'b0, 6'b001111, 1'b1, 6'(MC - 1 - i), 1'b0);
      end
      step("cancel_hit", 1'b0, 1'b1, 1'b1, 6'b000000, 1'b1, 6'(MC - 11), 1'b0);
      for (int i = 0; i < 4; i++) begin
         step("cancel_post", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      end

      // Cancel together with a request while in IDLE
      step("cancel_idle", 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 6'd0, 1'b0);
      step("cancel_idle_post", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);

      // Overlap with load-use; cancel asserted in DONE has no effect
      set_lu(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
      mc_run("ovl", 1'b0, 1'b1, 6'b000111);
      step("ovl_idle", 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0, 6'd0, 1'b0);
      set_lu(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

      // Reset for two clocks in the middle of RUN
      step("rstrun", 1'b0, 1'b1, 1'b0, 6'b001111, 1'b0, 6'd0, 1'b0);
      for (int i = 1; i < 5; i++) begin
         step("rstrun", 1'b0, 1'b1, 1'b0, 6'b001111, 1'b1, 6'(MC - 1 - i), 1'b0);
      end
      step("rstrun_r1", 1'b1, 1'b1, 1'b0, 6'b000000, 1'b1, 6'(MC - 6), 1'b0);
      step("rstrun_r2", 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step("rstrun_post", 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 6'd0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
